rv32i_multicycle_ctrl: RTL
==========================

Name: rv32i_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the RV32I datapath (PC, IR, register file, ALU, immediate generator, data bus) inside the MCU.
- Decodes opcode/funct3/funct7 from the datapath IR and steps each instruction through FETCH, DECODE, EXE, MEM and WB states.
- Raises one-cycle enables and mux selects, and waits on the data-bus ready handshake for loads and stores.
- Replaces the single-cycle control path so that instruction and data memory accesses can take more than one cycle.

Parameters:
- MEM_WAIT_MAX, 0, maximum number of MEM-state wait cycles before a bus error is declared; 0 disables the timeout.
- TO_W, 8, width of the wait counter; requires MEM_WAIT_MAX < 2**TO_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ir  in  32  instruction register contents from the datapath.
- br_taken  in  1  branch comparator result from the datapath, valid in EXE.
- dbus_ready  in  1  data bus accepted the write or returned read data.
- ir_en  out  1  latch the instruction memory output into IR.
- pc_en  out  1  update PC.
- pc_sel  out  2  next-PC source: 0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1.
- rf_we  out  1  register file write enable.
- rf_wd_sel  out  3  write-data source: 0=ALU, 1=load data, 2=imm (LUI), 3=PC+imm (AUIPC), 4=PC+4.
- alu_src_b  out  1  ALU operand B: 0=rs2, 1=imm.
- alu_ctrl  out  4  ALU operation code (package encoding).
- imm_sel  out  3  immediate format: I, S, B, U, J.
- dbus_req  out  1  data bus request, held until dbus_ready.
- dbus_we  out  1  data bus write (store) qualifier.
- dbus_size  out  3  funct3 passthrough during MEM.
- instr_retired  out  1  one-cycle pulse in the final state of each instruction.
- illegal_instr  out  1  one-cycle pulse on an unknown opcode.
- bus_err  out  1  one-cycle pulse on MEM timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- States: IDLE, FETCH, DECODE, EXE, MEM, WB.
- Reset: state is IDLE and every output is 0. IDLE outputs are all 0 and IDLE moves to FETCH unconditionally on the next clk. Reset asserted mid-instruction aborts it immediately: no rf_we and no pc_en.
- Outputs are combinational from the state register and ir (Moore with IR decode). alu_ctrl, imm_sel and alu_src_b are held stable from DECODE through WB.
- FETCH: ir_en=1 -> DECODE.
- DECODE: classify the opcode.
  - Known opcode -> EXE.
  - Unknown opcode: illegal_instr=1, pc_en=1, pc_sel=0, instr_retired=0 -> FETCH.
- EXE:
  - R/I/LUI/AUIPC -> WB.
  - L/S -> MEM, ALU computes rs1+imm.
  - B: pc_en=1, pc_sel = br_taken ? 1 : 0, instr_retired=1 -> FETCH.
  - JAL: rf_we=1, rf_wd_sel=4, pc_en=1, pc_sel=1, retired -> FETCH.
  - JALR: same as JAL with pc_sel=2.
- MEM:
  - dbus_req=1, dbus_we=(S), and the wait counter increments each cycle that dbus_ready=0.
  - On dbus_ready: S does pc_en=1, pc_sel=0, retired -> FETCH; L -> WB.
  - If MEM_WAIT_MAX!=0 and the counter equals MEM_WAIT_MAX with dbus_ready=0: bus_err=1, pc_en=1 (PC+4), no rf_we, not retired -> FETCH.
  - The counter clears on entry to MEM.
- WB: rf_we=1 with rf_wd_sel per class (R/I=0, L=1, LUI=2, AUIPC=3), pc_en=1, pc_sel=0, retired=1 -> FETCH.
- Writes to rd=x0 still assert rf_we; the register file ignores them.
- ALU decode:
  - funct7[5] selects SUB/SRA for R-type.
  - For I-type, funct7[5] selects SRA only when funct3=101; ADDI ignores it.
  - SLT is signed and SLTU is unsigned, selected by alu_ctrl.
- Latency in cycles (MEM counted with zero wait):
  - R/I/LUI/AUIPC: 4 (FETCH, DECODE, EXE, WB).
  - B/JAL/JALR: 3.
  - S: 4.
  - L: 5.
  - MEM adds one cycle for each dbus_ready=0 cycle.
- dbus_ready asserted outside MEM is ignored.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams (OPC_ARI_RTYPE, OPC_ARI_ITYPE, load/store/branch/LUI/AUIPC/JAL/JALR) and funct3/funct7 constants;
  - state_e enum;
  - alu_op_e (4-bit);
  - imm_sel_e, pc_sel_e and wd_sel_e enums.
- One natural sub-module: rv32i_alu_decoder (combinational: opcode, funct3, funct7[5] -> alu_ctrl). The FSM and wait counter stay in the top module.

Test Plan:
- Reset held 3 cycles then released -> state_o IDLE, all outputs 0 during reset; FETCH with ir_en=1 on the 2nd cycle after release.
- ir=add x8,x2,x1 (0x00110433) -> FETCH, DECODE, EXE, WB over 4 cycles; in WB rf_we=1, rf_wd_sel=0, alu_ctrl=ADD, pc_en=1, instr_retired=1.
- ir=sub (funct7=0x20), then ir=srai (funct7[5]=1, funct3=101) -> alu_ctrl=SUB, then alu_ctrl=SRA with alu_src_b=1.
- ir=lw x5,4(x1) with dbus_ready low 3 cycles then high -> dbus_req high 4 cycles in MEM, then WB with rf_wd_sel=1; total 8 cycles.
- ir=beq with br_taken=1, then again with br_taken=0 -> 3 cycles each; pc_sel=1, then pc_sel=0; rf_we never asserted.
- MEM_WAIT_MAX=4, ir=sw, dbus_ready stuck at 0 -> bus_err pulses on the 5th MEM cycle, pc_en=1, no retire, back to FETCH. Separately, ir=0xFFFFFFFF -> illegal_instr in DECODE, FETCH follows.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, funct fields,
// FSM states, ALU operations and datapath mux selects.
package rv32i_pkg;

    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXE    = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_JALR  = 2'd2
    } pc_sel_e;

    typedef enum logic [2:0] {
        WD_ALU   = 3'd0,
        WD_MEM   = 3'd1,
        WD_IMM   = 3'd2,
        WD_PCIMM = 3'd3,
        WD_PC4   = 3'd4
    } wd_sel_e;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_AUIPC   = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_cls_e;

    function automatic instr_cls_e classify(input logic [6:0] opcode);
        instr_cls_e cls;
        case (opcode)
            OPC_ARI_RTYPE: cls = CLS_R;
            OPC_ARI_ITYPE: cls = CLS_I;
            OPC_LOAD:      cls = CLS_LOAD;
            OPC_STORE:     cls = CLS_STORE;
            OPC_BRANCH:    cls = CLS_BRANCH;
            OPC_LUI:       cls = CLS_LUI;
            OPC_AUIPC:     cls = CLS_AUIPC;
            OPC_JAL:       cls = CLS_JAL;
            OPC_JALR:      cls = CLS_JALR;
            default:       cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
module rv32i_alu_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    output alu_op_e    o_alu_ctrl
);

    // Only R-type uses funct7[5] for SUB; both R and I use it to pick SRA.
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_opcode)
            OPC_ARI_RTYPE, OPC_ARI_ITYPE: begin
                case (i_funct3)
                    F3_ADD_SUB: o_alu_ctrl = ((i_opcode == OPC_ARI_RTYPE) && i_funct7_b5) ? ALU_SUB : ALU_ADD;
                    F3_SLL:     o_alu_ctrl = ALU_SLL;
                    F3_SLT:     o_alu_ctrl = ALU_SLT;
                    F3_SLTU:    o_alu_ctrl = ALU_SLTU;
                    F3_XOR:     o_alu_ctrl = ALU_XOR;
                    F3_SRL_SRA: o_alu_ctrl = i_funct7_b5 ? ALU_SRA : ALU_SRL;
                    F3_OR:      o_alu_ctrl = ALU_OR;
                    F3_AND:     o_alu_ctrl = ALU_AND;
                    default:    o_alu_ctrl = ALU_ADD;
                endcase
            end
            OPC_BRANCH: o_alu_ctrl = ALU_SUB;
            default:    o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXE/MEM/WB and drives
// datapath enables, mux selects and the data-bus handshake.
module rv32i_multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0,
    parameter int TO_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        br_taken,
    input  logic        dbus_ready,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [2:0]  rf_wd_sel,
    output logic        alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [2:0]  imm_sel,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [2:0]  dbus_size,
    output logic        instr_retired,
    output logic        illegal_instr,
    output logic        bus_err,
    output logic [2:0]  state_o
);

    localparam logic            LP_TO_EN    = (MEM_WAIT_MAX != 32'sd0);
    localparam logic [TO_W-1:0] LP_WAIT_MAX = TO_W'(MEM_WAIT_MAX);
    localparam logic [TO_W-1:0] LP_ONE      = TO_W'(1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [TO_W-1:0] r_wait_cnt;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7_b5;
    instr_cls_e      w_cls;
    alu_op_e         w_alu_op;
    imm_sel_e        w_imm_sel;
    logic            w_src_b;
    logic            w_dec_on;
    logic            w_timeout;
    logic            w_unused_ir;

    assign w_opcode    = ir[6:0];
    assign w_funct3    = ir[14:12];
    assign w_funct7_b5 = ir[30];
    assign w_unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
    assign w_cls       = classify(w_opcode);
    assign state_o     = r_state;

    rv32i_alu_decoder u_alu_dec (
        .i_opcode    (w_opcode),
        .i_funct3    (w_funct3),
        .i_funct7_b5 (w_funct7_b5),
        .o_alu_ctrl  (w_alu_op)
    );

    // Immediate format and ALU operand-B source per instruction class.
    always_comb begin
        w_imm_sel = IMM_I;
        w_src_b   = 1'b0;
        case (w_cls)
            CLS_R:                      begin w_imm_sel = IMM_I; w_src_b = 1'b0; end
            CLS_I, CLS_LOAD, CLS_JALR:  begin w_imm_sel = IMM_I; w_src_b = 1'b1; end
            CLS_STORE:                  begin w_imm_sel = IMM_S; w_src_b = 1'b1; end
            CLS_BRANCH:                 begin w_imm_sel = IMM_B; w_src_b = 1'b0; end
            CLS_LUI, CLS_AUIPC:         begin w_imm_sel = IMM_U; w_src_b = 1'b1; end
            CLS_JAL:                    begin w_imm_sel = IMM_J; w_src_b = 1'b1; end
            default:                    begin w_imm_sel = IMM_I; w_src_b = 1'b0; end
        endcase
    end

    // Decode-driven fields stay put from DECODE to WB; IR is not yet valid in FETCH.
    assign w_dec_on  = ((r_state == ST_DECODE) || (r_state == ST_EXE) ||
                        (r_state == ST_MEM) || (r_state == ST_WB)) && (w_cls != CLS_ILLEGAL);
    assign w_timeout = LP_TO_EN && (r_wait_cnt == LP_WAIT_MAX) && !dbus_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // MEM wait counter: held at zero outside MEM, saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_MEM) begin
            r_wait_cnt <= '0;
        end else if (!dbus_ready && (r_wait_cnt != '1)) begin
            r_wait_cnt <= r_wait_cnt + LP_ONE;
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        w_state_nxt   = r_state;
        ir_en         = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = PC_PLUS4;
        rf_we         = 1'b0;
        rf_wd_sel     = WD_ALU;
        dbus_req      = 1'b0;
        dbus_we       = 1'b0;
        dbus_size     = 3'd0;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;
        bus_err       = 1'b0;
        if (w_dec_on) begin
            alu_ctrl  = w_alu_op;
            imm_sel   = w_imm_sel;
            alu_src_b = w_src_b;
        end else begin
            alu_ctrl  = ALU_ADD;
            imm_sel   = IMM_I;
            alu_src_b = 1'b0;
        end
        case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                ir_en       = 1'b1;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_cls == CLS_ILLEGAL) begin
                    illegal_instr = 1'b1;
                    pc_en         = 1'b1;
                    w_state_nxt   = ST_FETCH;
                end else begin
                    w_state_nxt   = ST_EXE;
                end
            end
            ST_EXE: begin
                case (w_cls)
                    CLS_LOAD, CLS_STORE: w_state_nxt = ST_MEM;
                    CLS_BRANCH: begin
                        pc_en         = 1'b1;
                        pc_sel        = br_taken ? PC_IMM : PC_PLUS4;
                        instr_retired = 1'b1;
                        w_state_nxt   = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        rf_we         = 1'b1;
                        rf_wd_sel     = WD_PC4;
                        pc_en         = 1'b1;
                        pc_sel        = (w_cls == CLS_JAL) ? PC_IMM : PC_JALR;
                        instr_retired = 1'b1;
                        w_state_nxt   = ST_FETCH;
                    end
                    CLS_R, CLS_I, CLS_LUI, CLS_AUIPC: w_state_nxt = ST_WB;
                    default: w_state_nxt = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                dbus_req  = 1'b1;
                dbus_we   = (w_cls == CLS_STORE);
                dbus_size = w_funct3;
                if (dbus_ready) begin
                    if (w_cls == CLS_STORE) begin
                        pc_en         = 1'b1;
                        instr_retired = 1'b1;
                        w_state_nxt   = ST_FETCH;
                    end else begin
                        w_state_nxt   = ST_WB;
                    end
                end else if (w_timeout) begin
                    bus_err     = 1'b1;
                    pc_en       = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we         = 1'b1;
                pc_en         = 1'b1;
                instr_retired = 1'b1;
                w_state_nxt   = ST_FETCH;
                case (w_cls)
                    CLS_LOAD:  rf_wd_sel = WD_MEM;
                    CLS_LUI:   rf_wd_sel = WD_IMM;
                    CLS_AUIPC: rf_wd_sel = WD_PCIMM;
                    default:   rf_wd_sel = WD_ALU;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
